// File: rtl/id_ex_stage.sv
// ID/EX pipeline register feeding the 32-bit ALU.
// Captures decoded operands and control from decode, forwards results from
// EX/MEM and MEM/WB, selects the ALU operands, and detects load-use hazards.
//
// Pipeline flow: decode offers an instruction while id_valid=1. The stage
// accepts it on the rising edge unless stall=1 (load-use) or flush=1. While
// stall=1 decode must hold the same instruction, and the stage loads a bubble.
// A bubble has ex_valid=0 and every write control low, so downstream stages
// ignore it regardless of the operand values.
module id_ex_stage #(
    parameter int XLEN  = 32,
    parameter int RADDR = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [XLEN-1:0]  id_rs_data,
    input  logic [XLEN-1:0]  id_rt_data,
    input  logic [XLEN-1:0]  id_imm,
    input  logic [4:0]       id_shamt,
    input  logic [RADDR-1:0] id_rs,
    input  logic [RADDR-1:0] id_rt,
    input  logic [RADDR-1:0] id_rd,
    input  logic [3:0]       id_alu_control,
    input  logic             id_alu_src,
    input  logic             id_shift_imm,
    input  logic             id_mem_read,
    input  logic             id_mem_write,
    input  logic             id_reg_write,
    input  logic             flush,
    input  logic             exmem_reg_write,
    input  logic [RADDR-1:0] exmem_rd,
    input  logic [XLEN-1:0]  exmem_result,
    input  logic             memwb_reg_write,
    input  logic [RADDR-1:0] memwb_rd,
    input  logic [XLEN-1:0]  memwb_data,
    output logic             stall,
    output logic [XLEN-1:0]  alu_a,
    output logic [XLEN-1:0]  alu_b,
    output logic [3:0]       alu_control,
    output logic             ex_valid,
    output logic             ex_mem_read,
    output logic             ex_mem_write,
    output logic             ex_reg_write,
    output logic [RADDR-1:0] ex_rd,
    output logic [XLEN-1:0]  ex_store_data
);

    logic             valid_q,     valid_d;
    logic [XLEN-1:0]  rs_data_q,   rs_data_d;
    logic [XLEN-1:0]  rt_data_q,   rt_data_d;
    logic [XLEN-1:0]  imm_q,       imm_d;
    logic [4:0]       shamt_q,     shamt_d;
    logic [RADDR-1:0] rs_q,        rs_d;
    logic [RADDR-1:0] rt_q,        rt_d;
    logic [RADDR-1:0] rd_q,        rd_d;
    logic [3:0]       alu_ctl_q,   alu_ctl_d;
    logic             alu_src_q,   alu_src_d;
    logic             shift_imm_q, shift_imm_d;
    logic             mem_read_q,  mem_read_d;
    logic             mem_write_q, mem_write_d;
    logic             reg_write_q, reg_write_d;

    logic             hz;
    logic             load_bubble;
    logic [XLEN-1:0]  fwd_a;
    logic [XLEN-1:0]  fwd_b;

    // Load-use hazard: the load in this stage writes a register decode needs now.
    always_comb begin
        hz = valid_q && mem_read_q && (rd_q != '0) && id_valid &&
             ((id_rs == rd_q) || (id_rt == rd_q));
        stall = hz && !rst;
        load_bubble = flush || hz || !id_valid;
    end

    // Next-state: capture decode fields, or squash control into a bubble.
    always_comb begin
        valid_d     = id_valid;
        rs_data_d   = id_rs_data;
        rt_data_d   = id_rt_data;
        imm_d       = id_imm;
        shamt_d     = id_shamt;
        rs_d        = id_rs;
        rt_d        = id_rt;
        rd_d        = id_rd;
        alu_ctl_d   = id_alu_control;
        alu_src_d   = id_alu_src;
        shift_imm_d = id_shift_imm;
        mem_read_d  = id_mem_read;
        mem_write_d = id_mem_write;
        reg_write_d = id_reg_write;
        if (load_bubble) begin
            valid_d     = 1'b0;
            rd_d        = '0;
            alu_ctl_d   = 4'b0000;
            mem_read_d  = 1'b0;
            mem_write_d = 1'b0;
            reg_write_d = 1'b0;
        end
    end

    // Pipeline register with synchronous reset to an all-zero bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q     <= 1'b0;
            rs_data_q   <= '0;
            rt_data_q   <= '0;
            imm_q       <= '0;
            shamt_q     <= '0;
            rs_q        <= '0;
            rt_q        <= '0;
            rd_q        <= '0;
            alu_ctl_q   <= 4'b0000;
            alu_src_q   <= 1'b0;
            shift_imm_q <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            reg_write_q <= 1'b0;
        end else begin
            valid_q     <= valid_d;
            rs_data_q   <= rs_data_d;
            rt_data_q   <= rt_data_d;
            imm_q       <= imm_d;
            shamt_q     <= shamt_d;
            rs_q        <= rs_d;
            rt_q        <= rt_d;
            rd_q        <= rd_d;
            alu_ctl_q   <= alu_ctl_d;
            alu_src_q   <= alu_src_d;
            shift_imm_q <= shift_imm_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            reg_write_q <= reg_write_d;
        end
    end

    // Forwarding: the younger EX/MEM result wins over MEM/WB; r0 is never forwarded.
    always_comb begin
        fwd_a = rs_data_q;
        if (exmem_reg_write && (exmem_rd != '0) && (exmem_rd == rs_q)) begin
            fwd_a = exmem_result;
        end else if (memwb_reg_write && (memwb_rd != '0) && (memwb_rd == rs_q)) begin
            fwd_a = memwb_data;
        end

        fwd_b = rt_data_q;
        if (exmem_reg_write && (exmem_rd != '0) && (exmem_rd == rt_q)) begin
            fwd_b = exmem_result;
        end else if (memwb_reg_write && (memwb_rd != '0) && (memwb_rd == rt_q)) begin
            fwd_b = memwb_data;
        end
    end

    // Operand selection: shift amount beats immediate, which beats the rt value.
    always_comb begin
        alu_a = fwd_a;
        if (shift_imm_q) begin
            alu_b = {{(XLEN-5){1'b0}}, shamt_q};
        end else if (alu_src_q) begin
            alu_b = imm_q;
        end else begin
            alu_b = fwd_b;
        end
        ex_store_data = fwd_b;
        alu_control   = alu_ctl_q;
        ex_valid      = valid_q;
        ex_mem_read   = mem_read_q;
        ex_mem_write  = mem_write_q;
        ex_reg_write  = reg_write_q;
        ex_rd         = rd_q;
    end

endmodule
